// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single RegFile write port between the EX result path (A) and a
// buffered multi-cycle writer (B), keeping write-after-write order and bounding B starvation.
module regfile_wb_arbiter #(
    parameter int REG_LENGTH   = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_WAIT     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          aWr,
    input  logic [REG_ADDR_LEN-1:0]       aAddr,
    input  logic [REG_LENGTH-1:0]         aData,
    output logic                          exStall,
    input  logic                          bValid,
    input  logic [REG_ADDR_LEN-1:0]       bAddr,
    input  logic [REG_LENGTH-1:0]         bData,
    output logic                          bReady,
    output logic                          we,
    output logic [REG_ADDR_LEN-1:0]       wAddr,
    output logic [REG_LENGTH-1:0]         wData,
    input  logic [REG_ADDR_LEN-1:0]       qAddr,
    output logic                          qHit,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [REG_ADDR_LEN-1:0] entry_addr [FIFO_DEPTH];
    logic [REG_LENGTH-1:0]   entry_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   live;
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    stall_q;
    logic                    armed;

    logic                    head_live;
    logic                    a_issue;
    logic                    b_issue;
    logic                    pop;
    logic                    push;
    logic [FIFO_DEPTH-1:0]   live_next;
    logic [PTR_W-1:0]        head_next;
    logic [PTR_W-1:0]        tail_next;
    logic [CNT_W-1:0]        count_next;
    logic [WAIT_W-1:0]       wait_next;
    logic                    stall_next;
    logic                    q_hit;

    // Live bits are cleared on pop, so only occupied entries can ever be live.
    assign head_live = live[head];
    assign a_issue   = rst && !stall_q && aWr && (aAddr != '0);
    assign b_issue   = head_live && (stall_q || !a_issue);
    assign pop       = (count != '0) && (b_issue || !head_live);
    assign push      = bValid && bReady && (bAddr != '0);

    assign bReady    = armed && (count < DEPTH_C);
    assign exStall   = stall_q;
    assign fifoCount = count;
    assign qHit      = q_hit;

    always_comb begin
        we    = 1'b0;
        wAddr = '0;
        wData = '0;
        if (a_issue) begin
            we    = 1'b1;
            wAddr = aAddr;
            wData = aData;
        end else if (b_issue) begin
            we    = 1'b1;
            wAddr = entry_addr[head];
            wData = entry_data[head];
        end
    end

    // Squash older buffered writes to the register A overwrites; a same-cycle push is newer and stays live.
    always_comb begin
        live_next = live;
        if (a_issue) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (entry_addr[i] == aAddr) begin
                    live_next[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_next[head] = 1'b0;
        end
        if (push) begin
            live_next[tail] = 1'b1;
        end
    end

    always_comb begin
        head_next = head + PTR_W'(pop);
        tail_next = tail + PTR_W'(push);
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // The stall is only armed if the head will still be live when it takes effect.
    always_comb begin
        wait_next = wait_cnt;
        if (b_issue || !head_live) begin
            wait_next = '0;
        end else if (a_issue && (wait_cnt != WAIT_MAX)) begin
            wait_next = wait_cnt + 1'b1;
        end
        stall_next = (wait_next == WAIT_MAX) && live_next[head_next];
    end

    always_comb begin
        q_hit = 1'b0;
        if (qAddr != '0) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (live[i] && (entry_addr[i] == qAddr)) begin
                    q_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wait_cnt <= '0;
            stall_q  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            live     <= live_next;
            head     <= head_next;
            tail     <= tail_next;
            count    <= count_next;
            wait_cnt <= wait_next;
            stall_q  <= stall_next;
            armed    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[tail] <= bAddr;
            entry_data[tail] <= bData;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected RegFile writes go through a scoreboard
// queue and are matched against every observed write; control outputs are checked in line.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        aWr;
    logic [4:0]  aAddr;
    logic [31:0] aData;
    logic        exStall;
    logic        bValid;
    logic [4:0]  bAddr;
    logic [31:0] bData;
    logic        bReady;
    logic        we;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic [4:0]  qAddr;
    logic        qHit;
    logic [2:0]  fifoCount;

    wr_t exp_q [$];
    int  checks = 0;
    int  errors = 0;

    regfile_wb_arbiter #(
        .REG_LENGTH   (32),
        .REG_ADDR_LEN (5),
        .FIFO_DEPTH   (4),
        .MAX_WAIT     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aWr       (aWr),
        .aAddr     (aAddr),
        .aData     (aData),
        .exStall   (exStall),
        .bValid    (bValid),
        .bAddr     (bAddr),
        .bData     (bData),
        .bReady    (bReady),
        .we        (we),
        .wAddr     (wAddr),
        .wData     (wData),
        .qAddr     (qAddr),
        .qHit      (qHit),
        .fifoCount (fifoCount)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_write(input logic [4:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic apply_idle();
        aWr    = 1'b0;
        aAddr  = '0;
        aData  = '0;
        bValid = 1'b0;
        bAddr  = '0;
        bData  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every RegFile write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && we === 1'b1) begin
            wr_t w;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_write observed addr=%0d data=%0h expected no write", wAddr, wData);
            end
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check_output("write_addr", 32'(wAddr), 32'(w.addr));
                check_output("write_data", wData, w.data);
            end
        end
    end

    initial begin
        int  a_idx;
        int  b_issued;
        int  exp_count;
        logic exp_stall;

        rst   = 1'b0;
        qAddr = '0;
        apply_idle();
        repeat (2) @(negedge clk);
        check_output("reset_we", 32'(we), 32'd0);
        check_output("reset_count", 32'(fifoCount), 32'd0);
        check_output("reset_ready", 32'(bReady), 32'd0);
        check_output("reset_stall", 32'(exStall), 32'd0);
        check_output("reset_qhit", 32'(qHit), 32'd0);
        rst = 1'b1;
        #1;
        check_output("ready_before_edge", 32'(bReady), 32'd0);
        next_cycle();
        check_output("ready_after_edge", 32'(bReady), 32'd1);

        $display("[TB] port A zero-latency write");
        aWr = 1'b1; aAddr = 5'd5; aData = 32'h11;
        expect_write(5'd5, 32'h11);
        @(negedge clk);
        check_output("a_we", 32'(we), 32'd1);
        check_output("a_addr", 32'(wAddr), 32'd5);
        check_output("a_data", wData, 32'h11);
        next_cycle();
        aAddr = 5'd0; aData = 32'h22;
        @(negedge clk);
        check_output("a_r0_we", 32'(we), 32'd0);
        next_cycle();
        apply_idle();

        $display("[TB] port B stream with A idle");
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                bValid = 1'b1;
                bAddr  = 5'(7 + i);
                bData  = 32'h70 + 32'(i);
                expect_write(5'(7 + i), 32'h70 + 32'(i));
            end else begin
                bValid = 1'b0;
            end
            @(negedge clk);
            check_output("b_stream_count", 32'(fifoCount), (i == 0) ? 32'd0 : 32'd1);
            check_output("b_stream_we", 32'(we), (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) check_output("b_stream_addr", 32'(wAddr), 32'(6 + i));
            if (i < 4) check_output("b_stream_ready", 32'(bReady), 32'd1);
            next_cycle();
        end
        @(negedge clk);
        check_output("b_stream_drained", 32'(fifoCount), 32'd0);
        next_cycle();

        $display("[TB] port B write to r0");
        bValid = 1'b1; bAddr = 5'd0; bData = 32'h99;
        @(negedge clk);
        check_output("b_r0_ready", 32'(bReady), 32'd1);
        next_cycle();
        bValid = 1'b0;
        @(negedge clk);
        check_output("b_r0_count", 32'(fifoCount), 32'd0);
        check_output("b_r0_we", 32'(we), 32'd0);
        next_cycle();

        $display("[TB] WAW squash");
        qAddr = 5'd3;
        aWr = 1'b1; aAddr = 5'd20; aData = 32'hA0;
        expect_write(5'd20, 32'hA0);
        bValid = 1'b1; bAddr = 5'd3; bData = 32'h33;
        @(negedge clk);
        check_output("qhit_excludes_input", 32'(qHit), 32'd0);
        next_cycle();
        aAddr = 5'd3; aData = 32'hA3;
        expect_write(5'd3, 32'hA3);
        bValid = 1'b0;
        @(negedge clk);
        check_output("qhit_live", 32'(qHit), 32'd1);
        check_output("squash_count", 32'(fifoCount), 32'd1);
        next_cycle();
        aWr = 1'b0;
        @(negedge clk);
        check_output("qhit_after_squash", 32'(qHit), 32'd0);
        check_output("dead_head_count", 32'(fifoCount), 32'd1);
        check_output("dead_head_we", 32'(we), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("dead_head_popped", 32'(fifoCount), 32'd0);
        next_cycle();

        $display("[TB] WAW squash with same-cycle newer enqueue");
        aWr = 1'b1; aAddr = 5'd20; aData = 32'hB0;
        expect_write(5'd20, 32'hB0);
        bValid = 1'b1; bAddr = 5'd3; bData = 32'h33;
        @(negedge clk);
        next_cycle();
        aAddr = 5'd3; aData = 32'hB3;
        expect_write(5'd3, 32'hB3);
        bData = 32'h3B;
        expect_write(5'd3, 32'h3B);
        @(negedge clk);
        check_output("same_cycle_count", 32'(fifoCount), 32'd1);
        next_cycle();
        apply_idle();
        @(negedge clk);
        check_output("newer_count", 32'(fifoCount), 32'd2);
        check_output("newer_qhit", 32'(qHit), 32'd1);
        check_output("old_dead_we", 32'(we), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("newer_we", 32'(we), 32'd1);
        check_output("newer_data", wData, 32'h3B);
        next_cycle();
        @(negedge clk);
        check_output("newer_drained", 32'(fifoCount), 32'd0);
        check_output("newer_qhit_clear", 32'(qHit), 32'd0);
        next_cycle();
        qAddr = '0;

        $display("[TB] starvation bound under continuous port A traffic");
        a_idx = 0;
        b_issued = 0;
        exp_count = 0;
        for (int k = 0; k < 40; k++) begin
            exp_stall = (k >= 9) && (k % 9 == 0) && (k <= 36);
            aWr   = 1'b1;
            aAddr = 5'(20 + (a_idx % 8));
            aData = 32'h1000 + 32'(a_idx);
            if (k < 4) begin
                bValid = 1'b1;
                bAddr  = 5'(11 + k);
                bData  = 32'hB0 + 32'(k);
            end else begin
                bValid = 1'b0;
            end
            if (exp_stall) expect_write(5'(11 + b_issued), 32'hB0 + 32'(b_issued));
            else           expect_write(5'(20 + (a_idx % 8)), 32'h1000 + 32'(a_idx));
            @(negedge clk);
            check_output("stall", 32'(exStall), 32'(exp_stall));
            check_output("stall_count", 32'(fifoCount), 32'(exp_count));
            check_output("stall_ready", 32'(bReady), (exp_count < 4) ? 32'd1 : 32'd0);
            if (k < 4) exp_count++;
            if (exp_stall) begin
                exp_count--;
                b_issued++;
            end else begin
                a_idx++;
            end
            next_cycle();
        end
        apply_idle();
        @(negedge clk);
        check_output("stall_done_we", 32'(we), 32'd0);
        next_cycle();

        $display("[TB] reset mid-burst");
        qAddr = 5'd15;
        for (int k = 0; k < 3; k++) begin
            aWr = 1'b1; aAddr = 5'(20 + k); aData = 32'h2000 + 32'(k);
            expect_write(5'(20 + k), 32'h2000 + 32'(k));
            bValid = 1'b1; bAddr = 5'(15 + k); bData = 32'hC0 + 32'(k);
            @(negedge clk);
            next_cycle();
        end
        check_output("burst_count", 32'(fifoCount), 32'd3);
        rst = 1'b0;
        apply_idle();
        #1;
        check_output("midreset_we", 32'(we), 32'd0);
        check_output("midreset_count", 32'(fifoCount), 32'd0);
        check_output("midreset_ready", 32'(bReady), 32'd0);
        check_output("midreset_qhit", 32'(qHit), 32'd0);
        next_cycle();
        check_output("held_reset_ready", 32'(bReady), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        check_output("post_reset_ready", 32'(bReady), 32'd1);
        check_output("post_reset_count", 32'(fifoCount), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_output("post_reset_we", 32'(we), 32'd0);
        end
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single RegFile write port (we/wAddr/wData) between two writers:
  - the single-cycle EX result path (port A, cannot be back-pressured except via exStall);
  - a secondary multi-cycle writer (port B: load/mul-div writeback, valid/ready handshake).
- Buffers B writes in a small FIFO and preserves write-after-write ordering against EX.
- Bounds B starvation by stalling EX for one cycle.
- Provides a pending-write query so ID can stall reads of in-flight registers.

Parameters:
- REG_LENGTH, 32, data width of a register write
- REG_ADDR_LEN, 5, register address width
- FIFO_DEPTH, 4, port-B buffer entries (power of 2, >=2)
- MAX_WAIT, 8, cycles a live FIFO head may be blocked by port A before exStall forces it out (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low
- aWr  input  1  EX write request
- aAddr  input  REG_ADDR_LEN  EX destination register
- aData  input  REG_LENGTH  EX write data
- exStall  output  1  EX must hold and re-present its result next cycle
- bValid  input  1  port-B write request
- bAddr  input  REG_ADDR_LEN  port-B destination register
- bData  input  REG_LENGTH  port-B write data
- bReady  output  1  FIFO can accept a port-B write
- we  output  1  RegFile write enable
- wAddr  output  REG_ADDR_LEN  RegFile write address
- wData  output  REG_LENGTH  RegFile write data
- qAddr  input  REG_ADDR_LEN  ID read-address query
- qHit  output  1  a live FIFO entry targets qAddr
- fifoCount  output  log2(FIFO_DEPTH)+1  occupied entries, live and dead

Behaviour:
- Reset (rst=0, async):
  - FIFO empty, all entries dead, waitCnt=0.
  - Outputs: we=0, wAddr=0, wData=0, exStall=0, bReady=0, qHit=0, fifoCount=0.
  - bReady rises with the first clk edge after rst deasserts.
  - Reset mid-operation discards all buffered writes; no partial write is issued.
- Write port is combinational from aWr/aAddr/aData and the FIFO head. All state updates on the rising clk edge.
- Per-cycle selection, in priority order:
  1. exStall=1: aWr is ignored (EX holds). The live head issues (we=1, head addr/data) and pops; waitCnt clears.
  2. aWr=1 and aAddr!=0: A issues (we=1, aAddr, aData) with zero latency.
  3. FIFO head live: head issues and pops.
  4. Otherwise we=0, wAddr=0, wData=0.
- Dead head: popped in any cycle without using the port, even while A issues. At most one pop per cycle.
- Register 0: aWr with aAddr=0 never asserts we. bValid with bAddr=0 is accepted (handshake completes) but not enqueued.
- Enqueue:
  - Condition: bValid && bReady && bAddr!=0. Entry is written at the tail as live.
  - bReady = (fifoCount < FIFO_DEPTH), derived from registered state only.
  - Enqueue and pop may occur in the same cycle; fifoCount is unchanged.
- WAW squash:
  - When A issues to address X, every live FIFO entry with addr X becomes dead.
  - A B entry enqueued in that same cycle to X is newer and stays live.
- Starvation:
  - waitCnt increments (saturating at MAX_WAIT) each cycle a live head exists and A issues.
  - waitCnt clears when the head issues, or when the FIFO has no live head.
  - exStall is registered: exStall=1 in the cycle after waitCnt reaches MAX_WAIT, for exactly one cycle.
  - exStall=1 only if a live head still exists; if squash killed it, exStall stays 0 and waitCnt clears.
- qHit = (qAddr!=0) && any live entry.addr==qAddr. Combinational; excludes the current-cycle bValid input.
- FIFO pointers wrap modulo FIFO_DEPTH; full when fifoCount==FIFO_DEPTH.

Test Plan:
- Reset with rst=0 mid-burst (3 entries queued) → we=0, fifoCount=0, bReady=0 immediately; bReady=1 one edge after rst=1; no stale write issued.
- aWr=1 (aAddr=5, aData=0x11) with FIFO empty → same cycle we=1, wAddr=5, wData=0x11; aAddr=0 → we=0.
- bValid with bAddr=7, 8, 9, 10 and A idle → one write per cycle in order 7, 8, 9, 10, each one cycle after enqueue; fifoCount peaks at 1.
- Fill FIFO to 4 while aWr=1 continuously (MAX_WAIT=8) → bReady=0 at fifoCount=4; waitCnt reaches 8, next cycle exStall=1 and head issues; waitCnt resets and repeats every 9 cycles.
- FIFO holds live addr 3, then A writes addr 3 → entry dead, qHit(qAddr=3)=0, entry popped with no we; same-cycle bAddr=3 enqueue stays live and later writes.
- bValid with bAddr=0 → bReady handshake completes, fifoCount unchanged, no write issued.
